// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller:
// phase states, lamp codes and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MG_SR = 3'd0,
        ST_MY_SR = 3'd1,
        ST_AR1   = 3'd2,
        ST_MR_SG = 3'd3,
        ST_MR_SY = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } state_t;

    localparam logic [2:0] LT_R   = 3'b100;
    localparam logic [2:0] LT_Y   = 3'b010;
    localparam logic [2:0] LT_G   = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    localparam int unsigned DEF_TICK_CYCLES = 100;
    localparam int unsigned DEF_GREEN_MAIN  = 30;
    localparam int unsigned DEF_YELLOW      = 3;
    localparam int unsigned DEF_GREEN_SIDE  = 20;
    localparam int unsigned DEF_ALLRED      = 1;
    localparam int unsigned DEF_PED_MIN     = 5;

    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] side_l;
    } lights_t;

    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = ST_AR2;
        unique case (s)
            ST_AR2:   n = ST_MG_SR;
            ST_MG_SR: n = ST_MY_SR;
            ST_MY_SR: n = ST_AR1;
            ST_AR1:   n = ST_MR_SG;
            ST_MR_SG: n = ST_MR_SY;
            ST_MR_SY: n = ST_AR2;
            default:  n = ST_AR2;
        endcase
        return n;
    endfunction

    // Flash shows the blink phase on both roads; every other state is a fixed pair.
    function automatic lights_t lights_of(input state_t s, input logic blink);
        lights_t l;
        l = '{main_l: LT_R, side_l: LT_R};
        unique case (s)
            ST_MG_SR: l = '{main_l: LT_G, side_l: LT_R};
            ST_MY_SR: l = '{main_l: LT_Y, side_l: LT_R};
            ST_MR_SG: l = '{main_l: LT_R, side_l: LT_G};
            ST_MR_SY: l = '{main_l: LT_R, side_l: LT_Y};
            ST_FLASH: l = '{main_l: {1'b0, blink, 1'b0},
                            side_l: {1'b0, blink, 1'b0}};
            default:  l = '{main_l: LT_R, side_l: LT_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts clk cycles while enabled and
// pulses tick on the last count of each second.
module tick_gen #(
    parameter int unsigned pTICK_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = $clog2(pTICK_CYCLES);
    localparam logic [W-1:0] LAST = W'(pTICK_CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with pedestrian shortening
// of the main green and a flashing-yellow night mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned pTICK_CYCLES = DEF_TICK_CYCLES,
    parameter int unsigned pGREEN_MAIN  = DEF_GREEN_MAIN,
    parameter int unsigned pYELLOW      = DEF_YELLOW,
    parameter int unsigned pGREEN_SIDE  = DEF_GREEN_SIDE,
    parameter int unsigned pALLRED      = DEF_ALLRED,
    parameter int unsigned pPED_MIN     = DEF_PED_MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       night,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [6:0] remain,
    output logic       phase_last,
    output logic       tick,
    output logic       ped_walk
);

    localparam logic [6:0] GM_M1  = 7'(pGREEN_MAIN - 1);
    localparam logic [6:0] Y_M1   = 7'(pYELLOW - 1);
    localparam logic [6:0] GS_M1  = 7'(pGREEN_SIDE - 1);
    localparam logic [6:0] AR_M1  = 7'(pALLRED - 1);
    localparam logic [6:0] PED_M1 = 7'(pPED_MIN - 1);

    state_t     r_state;
    logic [6:0] r_remain;
    logic       r_blink;
    logic       r_ped_pend;
    lights_t    r_lights;
    logic       r_walk;

    logic       w_tick;
    logic       w_ped;
    logic       w_ped_cut;
    logic       w_enter_sg;
    logic       w_night_gate;
    state_t     w_adv_state;

    function automatic logic [6:0] dur_m1(input state_t s);
        logic [6:0] d;
        d = 7'd0;
        unique case (s)
            ST_MG_SR: d = GM_M1;
            ST_MY_SR: d = Y_M1;
            ST_MR_SY: d = Y_M1;
            ST_MR_SG: d = GS_M1;
            ST_AR1:   d = AR_M1;
            ST_AR2:   d = AR_M1;
            default:  d = 7'd0;
        endcase
        return d;
    endfunction

    tick_gen #(
        .pTICK_CYCLES(pTICK_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(w_tick)
    );

    // Night is only honoured at the end of an all-red clearance.
    assign w_night_gate = night &&
                          (r_state == ST_AR1 || r_state == ST_AR2);
    assign w_adv_state  = w_night_gate ? ST_FLASH : next_phase(r_state);

    assign w_ped      = r_ped_pend | ped_req;
    assign w_ped_cut  = (r_state == ST_MG_SR) && w_ped &&
                        (r_remain > PED_M1);
    assign w_enter_sg = w_tick && (r_state == ST_AR1) &&
                        (r_remain == 7'd0) && !night;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_AR2;
            r_remain   <= AR_M1;
            r_blink    <= 1'b0;
            r_ped_pend <= 1'b0;
            r_lights   <= lights_of(ST_AR2, 1'b0);
            r_walk     <= 1'b0;
        end else begin
            if (ped_req) begin
                r_ped_pend <= 1'b1;
            end else if (w_enter_sg) begin
                r_ped_pend <= 1'b0;
            end

            if (w_tick) begin
                if (r_state == ST_FLASH) begin
                    if (!night) begin
                        r_state  <= ST_AR2;
                        r_remain <= AR_M1;
                        r_blink  <= 1'b0;
                        r_lights <= lights_of(ST_AR2, 1'b0);
                        r_walk   <= 1'b0;
                    end else begin
                        r_blink  <= ~r_blink;
                        r_lights <= lights_of(ST_FLASH, ~r_blink);
                    end
                end else if (w_ped_cut) begin
                    r_remain <= PED_M1;
                end else if (r_remain == 7'd0) begin
                    r_state  <= w_adv_state;
                    r_remain <= dur_m1(w_adv_state);
                    r_blink  <= (w_adv_state == ST_FLASH);
                    r_lights <= lights_of(w_adv_state,
                                          w_adv_state == ST_FLASH);
                    r_walk   <= (w_adv_state == ST_MR_SG);
                end else begin
                    r_remain <= r_remain - 7'd1;
                end
            end
        end
    end

    assign main_light = r_lights.main_l;
    assign side_light = r_lights.side_l;
    assign remain     = r_remain;
    assign phase_last = (r_remain == 7'd0) && (r_state != ST_FLASH);
    assign tick       = w_tick;
    assign ped_walk   = r_walk;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized and directed bench for traffic_light_ctrl against a
// phase-table reference model.
module tb_traffic_light_ctrl;

    localparam int T   = 4;
    localparam int GM  = 5;
    localparam int YL  = 2;
    localparam int GS  = 3;
    localparam int AR  = 1;
    localparam int PED = 2;

    // Phase table in cycle order: MG, MY, AR1, SG, SY, AR2; index 6 is flash.
    localparam int DUR[6] = '{GM, YL, AR, GS, YL, AR};
    localparam logic [2:0] MAIN_T[6] =
        '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] SIDE_T[6] =
        '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       night = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [6:0] remain;
    logic       phase_last;
    logic       tick;
    logic       ped_walk;
    logic [15:0] w_dut;

    int checks = 0;
    int passed = 0;

    int m_pre = 0;
    int m_ph = 5;
    int m_rem = 0;
    bit m_blink = 0;
    bit m_pend = 0;

    traffic_light_ctrl #(
        .pTICK_CYCLES(T),
        .pGREEN_MAIN (GM),
        .pYELLOW     (YL),
        .pGREEN_SIDE (GS),
        .pALLRED     (AR),
        .pPED_MIN    (PED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .night     (night),
        .ped_req   (ped_req),
        .main_light(main_light),
        .side_light(side_light),
        .remain    (remain),
        .phase_last(phase_last),
        .tick      (tick),
        .ped_walk  (ped_walk)
    );

    always #5 clk = ~clk;

    assign w_dut = {main_light, side_light, remain,
                    phase_last, tick, ped_walk};

    always @(posedge clk) begin : model
        bit tk;
        bit sg_entry;
        int nx;
        tk = en && (m_pre == T - 1);
        sg_entry = 0;
        if (rst) begin
            m_pre   <= 0;
            m_ph    <= 5;
            m_rem   <= AR - 1;
            m_blink <= 0;
            m_pend  <= 0;
        end else begin
            if (en) m_pre <= (m_pre + 1) % T;
            if (tk) begin
                if (m_ph == 6) begin
                    if (!night) begin
                        m_ph    <= 5;
                        m_rem   <= AR - 1;
                        m_blink <= 0;
                    end else begin
                        m_blink <= !m_blink;
                    end
                end else if (m_ph == 0 && (m_pend || ped_req) &&
                             m_rem > PED - 1) begin
                    m_rem <= PED - 1;
                end else if (m_rem == 0) begin
                    if ((m_ph == 2 || m_ph == 5) && night) begin
                        m_ph    <= 6;
                        m_rem   <= 0;
                        m_blink <= 1;
                    end else begin
                        nx = (m_ph + 1) % 6;
                        m_ph  <= nx;
                        m_rem <= DUR[nx] - 1;
                        sg_entry = (nx == 3);
                    end
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
            if (ped_req) m_pend <= 1;
            else if (sg_entry) m_pend <= 0;
        end
    end

    function automatic logic [15:0] exp_vec();
        logic [2:0] mn;
        logic [2:0] sd;
        if (m_ph == 6) begin
            mn = {1'b0, m_blink, 1'b0};
            sd = mn;
        end else begin
            mn = MAIN_T[m_ph];
            sd = SIDE_T[m_ph];
        end
        return {mn, sd, 7'(m_rem), 1'(m_rem == 0 && m_ph != 6),
                1'(en && m_pre == T - 1), 1'(m_ph == 3)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        night = 1'b0;
        ped_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        night = 1'b1;
        ped_req = 1'b1;
        step();
        step();
        checks++;
        if ({main_light, side_light} !== 6'b100100) begin
            $display("FAIL reset_lights got %b exp 100100",
                     {main_light, side_light});
        end else passed++;
        checks++;
        if ({remain, tick, ped_walk} !== {7'(AR - 1), 2'b00}) begin
            $display("FAIL reset_rem_tick_walk got %h exp %h",
                     {remain, tick, ped_walk}, {7'(AR - 1), 2'b00});
        end else passed++;
        checks++;
        if (w_dut !== exp_vec()) begin
            $display("FAIL reset_model got %h exp %h", w_dut, exp_vec());
        end else passed++;
        rst = 1'b0;
        night = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic test_normal();
        int n;
        int g;
        do_reset();
        en = 1'b1;
        n = 0;
        while (main_light !== 3'b001 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != T * AR) begin
            $display("FAIL normal_ar2_len got %0d exp %0d", n, T * AR);
        end else passed++;
        g = 0;
        for (int i = 0; i < 56; i++) begin
            if (main_light === 3'b001) g++;
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL normal_cyc%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            step();
        end
        checks++;
        if (g != T * GM) begin
            $display("FAIL normal_mg_len got %0d exp %0d", g, T * GM);
        end else passed++;
        checks++;
        if ({main_light, remain} !== {3'b001, 7'(GM - 1)}) begin
            $display("FAIL normal_period got %h exp %h",
                     {main_light, remain}, {3'b001, 7'(GM - 1)});
        end else passed++;
    endtask

    task automatic test_freeze();
        int n;
        do_reset();
        en = 1'b1;
        n = 0;
        while (!(m_ph == 0 && m_rem == 3) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!(m_ph == 0 && m_rem == 3)) begin
            $display("FAIL freeze_wait got timeout exp MG remain 3");
        end else passed++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (w_dut !== exp_vec() || remain !== 7'd3 ||
                main_light !== 3'b001) begin
                $display("FAIL freeze_hold%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
        end
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL freeze_resume%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
        end
    endtask

    task automatic test_ped();
        int n;
        int walk_bad;
        do_reset();
        en = 1'b1;
        n = 0;
        while (!(m_ph == 0 && m_rem == GM - 1) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!(m_ph == 0 && m_rem == GM - 1)) begin
            $display("FAIL ped_wait got timeout exp MG remain 4");
        end else passed++;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        walk_bad = 0;
        for (int i = 0; i < 70; i++) begin
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL ped_cyc%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            if (ped_walk !== (side_light === 3'b001)) walk_bad++;
            step();
        end
        checks++;
        if (walk_bad != 0) begin
            $display("FAIL ped_walk_sg got %0d bad exp 0", walk_bad);
        end else passed++;
    endtask

    task automatic test_ped_outside();
        int n;
        do_reset();
        en = 1'b1;
        n = 0;
        while (!(m_ph == 3) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (m_ph != 3) begin
            $display("FAIL pedsg_wait got timeout exp SG");
        end else passed++;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL pedsg_cyc%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            step();
        end
    endtask

    task automatic test_night();
        int n;
        do_reset();
        en = 1'b1;
        n = 0;
        while (m_ph != 0 && n < 200) begin
            step();
            n++;
        end
        night = 1'b1;
        n = 0;
        while (m_ph != 6 && n < 300) begin
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL night_in%0d got %h exp %h",
                         n, w_dut, exp_vec());
            end else passed++;
            step();
            n++;
        end
        checks++;
        if (m_ph != 6) begin
            $display("FAIL night_wait got timeout exp FLASH");
        end else passed++;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (w_dut !== exp_vec() || main_light !== side_light) begin
                $display("FAIL night_flash%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            step();
        end
        night = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL night_out%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        en = 1'b1;
        n = 0;
        while (m_ph != 4 && n < 200) begin
            step();
            n++;
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({main_light, side_light, remain, tick} !==
            {6'b100100, 7'(AR - 1), 1'b0}) begin
            $display("FAIL rstmid_state got %h exp %h",
                     {main_light, side_light, remain, tick},
                     {6'b100100, 7'(AR - 1), 1'b0});
        end else passed++;
        for (int i = 0; i < 60; i++) begin
            step();
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL rstmid_cyc%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 8) != 0;
            ped_req = ($urandom % 40) == 0;
            if (($urandom % 250) == 0) night = ~night;
            rst = ($urandom % 1500) == 0;
            step();
            checks++;
            if (w_dut !== exp_vec()) begin
                $display("FAIL random_cyc%0d got %h exp %h",
                         i, w_dut, exp_vec());
            end else passed++;
            checks++;
            if (main_light != 3'b100 && side_light != 3'b100 &&
                m_ph != 6) begin
                $display("FAIL random_conflict got %b/%b exp one red",
                         main_light, side_light);
            end else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normal();
        test_freeze();
        test_ped();
        test_ped_outside();
        test_night();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  pTICK_CYCLES  100  clk cycles per second tick (2..128)
  pGREEN_MAIN   30   main-road green duration, seconds (1..100)
  pYELLOW       3    yellow duration for either road, seconds (1..100)
  pGREEN_SIDE   20   side-road green duration, seconds (1..100)
  pALLRED       1    all-red clearance duration, seconds (1..100)
  pPED_MIN      5    main-green seconds left after a pedestrian request (1..pGREEN_MAIN)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk         in   1  single clock, rising edge
  rst         in   1  synchronous, active-high reset
  en          in   1  run enable; 0 freezes all timing
  night       in   1  request for flashing-yellow night mode
  ped_req     in   1  pedestrian crossing request; single-cycle pulse or level
  main_light  out  3  {R,Y,G}, one-hot or 000
  side_light  out  3  {R,Y,G}, one-hot or 000
  remain      out  7  seconds left in the current phase minus 1
  phase_last  out  1  remain==0 and state!=FLASH
  tick        out  1  one-cycle second pulse
  ped_walk    out  1  walk signal, high only in MR_SG

Function
REQ-003 Prescaler SHALL count 0..pTICK_CYCLES-1 while en=1, wrap to 0, and hold its value while en=0.
REQ-004 tick SHALL be 1 in a cycle where en=1 and the prescaler equals pTICK_CYCLES-1; state, remain and blink update only on that edge.
REQ-005 States SHALL be MG_SR, MY_SR, AR1, MR_SG, MR_SY, AR2 and FLASH.
REQ-006 Normal cycle SHALL be AR2->MG_SR->MY_SR->AR1->MR_SG->MR_SY->AR2.
REQ-007 A phase SHALL advance on a tick with remain==0; otherwise a tick decrements remain.
REQ-008 On phase entry, remain SHALL load its duration minus 1: MG pGREEN_MAIN, MY/SY pYELLOW, AR1/AR2 pALLRED, SG pGREEN_SIDE.
REQ-009 Lights SHALL be: MG_SR G/R, MY_SR Y/R, AR1 R/R, MR_SG R/G, MR_SY R/Y, AR2 R/R (main/side).
REQ-010 ped_pend SHALL set on any cycle with ped_req=1 and clear on entry to MR_SG.
REQ-011 On a tick in MG_SR with (ped_pend|ped_req)=1 and remain>pPED_MIN-1, remain SHALL load pPED_MIN-1 instead of decrementing.
REQ-012 A pedestrian request outside MG_SR SHALL NOT alter timing.
REQ-013 ped_walk SHALL equal 1 exactly while in MR_SG.
REQ-014 night SHALL be sampled only at the end of AR1 or AR2 (tick with remain==0); night=1 there SHALL enter FLASH instead of the next green.
REQ-015 FLASH: main_light=side_light={0,blink,0}; blink SHALL toggle every tick; remain SHALL hold 0.
REQ-016 Exit from FLASH SHALL occur on a tick with night=0, SHALL enter AR2 with remain=pALLRED-1, and SHALL clear blink.
REQ-017 No green or yellow SHALL ever be shown on both roads simultaneously except in FLASH.

Reset
REQ-018 With rst=1 at a clock edge, the block SHALL set state=AR2, remain=pALLRED-1, prescaler=0, ped_pend=0 and blink=0 on that edge.
REQ-019 After reset, outputs SHALL be main_light=side_light=100, tick=0 and ped_walk=0; reset SHALL take priority over en, night and ped_req.

Structure
REQ-020 Package traffic_pkg SHALL hold the state encoding, the light encodings (LT_R=100, LT_Y=010, LT_G=001, LT_OFF=000) and the default durations.
REQ-021 The prescaler SHALL be a sub-module tick_gen (ports clk, rst, en, tick).
REQ-022 Phase timer, state register and ped_pend SHALL reside in traffic_light_ctrl.

Verification
Bench parameters: pTICK_CYCLES=4, pGREEN_MAIN=5, pYELLOW=2, pGREEN_SIDE=3, pALLRED=1, pPED_MIN=2.
REQ-023 Release rst, hold en=1 -> AR2 for 4 cycles; MG 20 cycles with remain 4..0; MY 8; AR1 4; SG 12; SY 8; period 56 cycles.
REQ-024 en=0 for 10 cycles while MG remain=3 -> remain, lights and prescaler frozen; resume gives 10 extra cycles of MG total.
REQ-025 ped_req pulse while MG remain=4 -> next tick remain=1, MY 8 cycles later; ped_walk=1 for all of MR_SG; ped_pend=0 afterward.
REQ-026 ped_req while MG remain=1, or during SG -> timing identical to REQ-023.
REQ-027 night=1 during MG -> MY and AR1 complete, then FLASH with yellow toggling every 4 cycles; night=0 -> next tick AR2 (4 cycles), then MG.
REQ-028 rst=1 for one cycle during MR_SY -> next cycle both lights 100, remain=0, tick=0; normal cycle resumes from AR2.
